echo_effect: RTL and testbench

Feedback-echo stage between the three-voice mixer and `codec_conditioner`. It takes each mixed 16-bit sample, adds an attenuated copy of the output from `delay_len` samples earlier, and saturates the result. It then stores the result in a circular delay buffer and presents it to the codec conditioner as a one-cycle-valid sample. It also provides a programmable clear, for example on song change, and an overrun flag.

---
 rtl/echo_pkg.sv | 21 ++
 rtl/echo_ram.sv | 26 ++
 rtl/echo_effect.sv | 136 +++++++++++++
 tb/tb_echo_effect.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_pkg : shared states and constants for the echo_effect stage. Rev 1.0
// ---------------------------------------------------------------------------
package echo_pkg;

  localparam int ECHO_ADDR_W = 12;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    MIX   = 3'd3,
    WRITE = 3'd4
  } echo_state_t;

endpackage
`default_nettype wire

// File: rtl/echo_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_ram : single-port DEPTH x 16 delay buffer, synchronous read. Rev 1.0
// ---------------------------------------------------------------------------
module echo_ram #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/echo_effect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// echo_effect : feedback echo with saturation, circular delay buffer. Rev 1.0
// ---------------------------------------------------------------------------
module echo_effect
  import echo_pkg::*;
#(
  parameter int ADDR_W = ECHO_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       sample_in,
  input  logic              sample_in_valid,
  input  logic              enable,
  input  logic [1:0]        decay,
  input  logic [ADDR_W-1:0] delay_len,
  input  logic              clear,
  output logic [15:0]       sample_out,
  output logic              sample_out_valid,
  output logic              ready,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  echo_state_t        state, state_nx;
  logic [ADDR_W-1:0]  wr_ptr, rd_addr, clr_cnt;
  logic signed [15:0] sample, mix_reg;
  logic               en_l;
  logic [2:0]         shift;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [15:0]        ram_wdata, ram_q;

  logic signed [15:0] echo;
  logic signed [16:0] sum;
  logic signed [15:0] sat;

  echo_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_cnt == LAST) state_nx = IDLE;
      IDLE:    if (sample_in_valid) state_nx = READ;
      READ:    state_nx = MIX;
      MIX:     state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
    if (clear) state_nx = CLEAR;
  end

  // A clear landing on WRITE abandons the sample, so its write is suppressed too.
  always_comb begin
    ram_we    = (state == CLEAR) || ((state == WRITE) && !clear);
    ram_addr  = rd_addr;
    ram_wdata = '0;
    case (state)
      CLEAR:   ram_addr = clr_cnt;
      WRITE: begin
        ram_addr  = wr_ptr;
        ram_wdata = mix_reg;
      end
      default: ram_addr = rd_addr;
    endcase
  end

  always_comb begin
    echo = $signed(ram_q) >>> shift;
    sum  = {echo[15], echo} + {sample[15], sample};
    sat  = sum[15:0];
    if (sum > 17'sd32767)       sat = SAT_MAX;
    else if (sum < -17'sd32768) sat = SAT_MIN;
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= CLEAR;
      wr_ptr           <= '0;
      rd_addr          <= '0;
      clr_cnt          <= '0;
      sample           <= '0;
      mix_reg          <= '0;
      en_l             <= 1'b0;
      shift            <= 3'd1;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_nx;
      sample_out_valid <= 1'b0;
      if (clear) begin
        clr_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        if (sample_in_valid && (state == READ || state == MIX || state == WRITE))
          overrun <= 1'b1;
        case (state)
          CLEAR: begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST) begin
              clr_cnt <= '0;
              wr_ptr  <= '0;
            end
          end
          IDLE: if (sample_in_valid) begin
            sample  <= sample_in;
            en_l    <= enable;
            shift   <= {1'b0, decay} + 3'd1;
            rd_addr <= wr_ptr - delay_len;
          end
          MIX: mix_reg <= en_l ? sat : sample;
          WRITE: begin
            sample_out       <= mix_reg;
            sample_out_valid <= 1'b1;
            wr_ptr           <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_effect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_echo_effect : scoreboard bench for echo_effect. Rev 1.0
// ---------------------------------------------------------------------------
module tb_echo_effect;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_in_valid = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  decay = '0;
  logic [11:0] delay_len = '0;
  logic        clear = 1'b0;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        ready;
  logic        overrun;

  echo_effect dut (
    .clk              (clk),
    .reset            (reset),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .enable           (enable),
    .decay            (decay),
    .delay_len        (delay_len),
    .clear            (clear),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .ready            (ready),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sample_out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", {16'd0, sample_out}, {16'd0, e.data});
        check("out_latency", cyc, e.due);
      end
    end
  end

  // Called just after a posedge; leaves the bench 4 cycles later, ready for the next sample.
  task automatic send(input logic [15:0] s, input logic [15:0] e);
    exp_t x;
    sample_in       = s;
    sample_in_valid = 1'b1;
    x.data = e;
    x.due  = cyc + 4;
    sb.push_back(x);
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag, input bit quiet);
    int n;
    bit bad;
    n   = 0;
    bad = 1'b0;
    @(negedge clk);
    while (!ready && n < 3 * DEPTH) begin
      if (quiet && (sample_out !== 16'd0 || sample_out_valid !== 1'b0 || overrun !== 1'b0))
        bad = 1'b1;
      n++;
      @(negedge clk);
    end
    check(tag, n, DEPTH);
    if (quiet) check({tag, "_quiet"}, {31'd0, bad}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_out", {16'd0, sample_out}, 32'd0);
    check("rst_valid", {31'd0, sample_out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_ready("rst_ready_len", 1'b1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_overrun", {31'd0, overrun}, 32'd0);
    wait_ready("clr_ready_len", 1'b0);
  endtask

  initial begin
    do_reset();

    // Impulse: every 4th output halves.
    delay_len = 12'd4;
    decay     = 2'd0;
    enable    = 1'b1;
    send(16'h4000, 16'h4000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h2000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h1000);

    // Positive and negative saturation.
    do_clear();
    delay_len = 12'd1;
    send(16'h7000, 16'h7000);
    send(16'h7000, 16'h7FFF);
    do_reset();
    send(16'h9000, 16'h9000);
    send(16'h9000, 16'h8000);

    // Passthrough still feeds the buffer; re-enabling echoes it.
    do_clear();
    enable    = 1'b0;
    delay_len = 12'd4;
    send(16'h1234, 16'h1234);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h0000);
    enable = 1'b1;
    send(16'h0000, 16'h091A);
    decay     = 2'd3;
    delay_len = 12'd5;
    send(16'h0000, 16'h0123);
    decay = 2'd0;

    // Overrun: second valid lands in MIX and is dropped.
    do_clear();
    delay_len = 12'd0;
    check("ovr_before", {31'd0, overrun}, 32'd0);
    begin
      exp_t x;
      sample_in       = 16'h0AAA;
      sample_in_valid = 1'b1;
      x.data = 16'h0AAA;
      x.due  = cyc + 4;
      sb.push_back(x);
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      @(posedge clk); #1;
      sample_in       = 16'h7777;
      sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
    check("ovr_set", {31'd0, overrun}, 32'd1);
    do_clear();

    // Abort: clear during MIX yields no output; history stays zero.
    sample_in       = 16'h5555;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_ready("abort_ready_len", 1'b0);
    delay_len = 12'd0;
    send(16'h1111, 16'h1111);

    repeat (10) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
